// File: rtl/spi_multi_initiator.sv
// -----------------------------------------------------------------------------
// spi_multi_initiator
//
// Purpose:
//    SPI initiator with a small command FIFO. Each FIFO entry {sel, data} becomes
//    one frame: SETUP (1 tick), SHIFT (2*DATA_WIDTH ticks, sclk toggling on every
//    tick), HOLD (CS_N_HOLD_COUNT ticks), then GAP (MIN_GAP clk cycles) with all
//    chip selects high. One tick is SCLK_DIVIDER clk cycles. SPI mode {CPOL,CPHA}
//    is latched at frame start. The MISO word is presented on rdata/rsel with a
//    one-cycle rvalid strobe when the frame ends.
//
// Ports:
//    clk       system clock
//    rst       asynchronous reset, active high
//    wdata     frame payload to push (MSB sent first)
//    wsel      chip-select index for the pushed frame
//    we        push strobe, accepted only while full=0
//    full      FIFO full (registered)
//    overflow  high in the cycle a push is attempted while full
//    mode      {CPOL,CPHA}, sampled when a frame starts
//    busy      high from FIFO pop until the inter-frame gap ends
//    miso      serial data from target
//    rdata     captured MISO word
//    rsel      chip-select index of the captured word
//    rvalid    one-cycle pulse when rdata/rsel update
//    sclk      SPI clock
//    cs_n      active-low chip selects, at most one low
//    mosi      serial data to target
// -----------------------------------------------------------------------------
module spi_multi_initiator #(
   parameter int DATA_WIDTH      = 16,
   parameter int NUM_CS          = 2,
   parameter int SEL_W           = 1,
   parameter int SCLK_DIVIDER    = 8,
   parameter int FIFO_DEPTH      = 4,
   parameter int CS_N_HOLD_COUNT = 3,
   parameter int MIN_GAP         = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [SEL_W-1:0]      wsel,
   input  logic                  we,
   output logic                  full,
   output logic                  overflow,
   input  logic [1:0]            mode,
   output logic                  busy,
   input  logic                  miso,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [SEL_W-1:0]      rsel,
   output logic                  rvalid,
   output logic                  sclk,
   output logic [NUM_CS-1:0]     cs_n,
   output logic                  mosi
);

   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = SEL_W + DATA_WIDTH;
   localparam int STEP_W  = 12;

   localparam logic [7:0]        DIV_LAST  = 8'(SCLK_DIVIDER - 1);
   localparam logic [STEP_W-1:0] EDGE_LAST = STEP_W'(2 * DATA_WIDTH - 1);
   localparam logic [STEP_W-1:0] HOLD_LAST = STEP_W'(CS_N_HOLD_COUNT - 1);
   localparam logic [STEP_W-1:0] GAP_LAST  = STEP_W'(MIN_GAP - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

   // ---------------- command FIFO ----------------
   logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  full_q;
   logic                  push, pop;
   logic [ENTRY_W-1:0]    head;
   logic [SEL_W-1:0]      head_sel;
   logic [DATA_WIDTH-1:0] head_data;
   logic [NUM_CS-1:0]     cs_dec;

   state_t                state_q;

   // A push while full is dropped regardless of a simultaneous pop.
   assign push      = we && !full_q;
   assign pop       = (state_q == S_IDLE) && (count_q != '0);
   assign head      = fifo_mem[rd_ptr_q];
   assign head_sel  = head[ENTRY_W-1 -: SEL_W];
   assign head_data = head[DATA_WIDTH-1:0];
   assign overflow  = we && full_q;

   // Out-of-range selects decode to no active line: the frame still runs.
   for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
      assign cs_dec[gi] = (head_sel == SEL_W'(gi));
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= {wsel, wdata};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
         full_q  <= (count_d == CNT_FULL);
      end
   end

   // ---------------- frame engine ----------------
   logic [7:0]            div_q;
   logic [STEP_W-1:0]     step_q;   // edge index in SHIFT, tick index in HOLD, cycle index in GAP
   logic                  cpol_q, cpha_q;
   logic [SEL_W-1:0]      sel_q;
   logic [DATA_WIDTH-1:0] tx_q, rx_q;
   logic                  sclk_q, mosi_q, busy_q, rvalid_q;
   logic [NUM_CS-1:0]     cs_n_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [SEL_W-1:0]      rsel_q;
   logic                  tick, sample_edge, shift_edge;

   assign tick        = (div_q == DIV_LAST);
   // Even edge indices are leading edges. CPHA=0 samples on leading edges,
   // CPHA=1 on trailing; the other edge shifts, except the very last one.
   assign sample_edge = (step_q[0] == cpha_q);
   assign shift_edge  = (step_q[0] != cpha_q) && (step_q != EDGE_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         div_q    <= '0;
         step_q   <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         sel_q    <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         busy_q   <= 1'b0;
         cs_n_q   <= '1;
         rdata_q  <= '0;
         rsel_q   <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               sclk_q <= mode[1];
               if (pop) begin
                  state_q <= S_SETUP;
                  div_q   <= '0;
                  cpol_q  <= mode[1];
                  cpha_q  <= mode[0];
                  sel_q   <= head_sel;
                  cs_n_q  <= ~cs_dec;
                  busy_q  <= 1'b1;
                  if (!mode[0]) begin
                     // CPHA=0: MSB must be valid before the first (sampling) edge.
                     mosi_q <= head_data[DATA_WIDTH-1];
                     tx_q   <= {head_data[DATA_WIDTH-2:0], 1'b0};
                  end else begin
                     tx_q   <= head_data;
                  end
               end
            end
            S_SETUP: begin
               if (tick) begin
                  state_q <= S_SHIFT;
                  div_q   <= '0;
                  step_q  <= '0;
               end else begin
                  div_q <= div_q + 8'd1;
               end
            end
            S_SHIFT: begin
               if (tick) begin
                  div_q  <= '0;
                  sclk_q <= ~sclk_q;
                  if (sample_edge) rx_q <= {rx_q[DATA_WIDTH-2:0], miso};
                  if (shift_edge) begin
                     mosi_q <= tx_q[DATA_WIDTH-1];
                     tx_q   <= {tx_q[DATA_WIDTH-2:0], 1'b0};
                  end
                  if (step_q == EDGE_LAST) begin
                     state_q <= S_HOLD;
                     step_q  <= '0;
                  end else begin
                     step_q <= step_q + STEP_W'(1);
                  end
               end else begin
                  div_q <= div_q + 8'd1;
               end
            end
            S_HOLD: begin
               if (tick) begin
                  div_q <= '0;
                  if (step_q == HOLD_LAST) begin
                     state_q  <= S_GAP;
                     step_q   <= '0;
                     cs_n_q   <= '1;
                     rdata_q  <= rx_q;
                     rsel_q   <= sel_q;
                     rvalid_q <= 1'b1;
                  end else begin
                     step_q <= step_q + STEP_W'(1);
                  end
               end else begin
                  div_q <= div_q + 8'd1;
               end
            end
            S_GAP: begin
               sclk_q <= mode[1];
               if (step_q == GAP_LAST) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  step_q <= step_q + STEP_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign full   = full_q;
   assign busy   = busy_q;
   assign rdata  = rdata_q;
   assign rsel   = rsel_q;
   assign rvalid = rvalid_q;
   assign sclk   = sclk_q;
   assign cs_n   = cs_n_q;
   assign mosi   = mosi_q;

endmodule

// File: tb/tb_spi_multi_initiator.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus pushes an expected-frame record per accepted
// command; the monitor pops one at each frame start and checks the whole frame
// (select line, idle level, bit stream, edge counts, cs_n width, read-back).
module tb_spi_multi_initiator;

   localparam int W      = 16;
   localparam int NCS    = 2;
   localparam int SW     = 1;
   localparam int H      = 2;
   localparam int DEPTH  = 4;
   localparam int HOLD   = 3;
   localparam int GAP    = 4;
   localparam int CS_LOW = (1 + 2 * W + HOLD) * H;   // 72 clk cycles

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [W-1:0]   wdata = '0;
   logic [SW-1:0]  wsel = '0;
   logic           we = 1'b0;
   logic           full, overflow, busy, rvalid, sclk, mosi;
   logic [1:0]     mode = 2'b00;
   logic           miso;
   logic [W-1:0]   rdata;
   logic [SW-1:0]  rsel;
   logic [NCS-1:0] cs_n;

   logic           use_tgt  = 1'b0;
   logic           miso_tgt = 1'b0;
   logic [W-1:0]   tgt_word = '0;
   assign miso = use_tgt ? miso_tgt : mosi;

   always #5 clk = ~clk;

   spi_multi_initiator #(
      .DATA_WIDTH(W), .NUM_CS(NCS), .SEL_W(SW), .SCLK_DIVIDER(H),
      .FIFO_DEPTH(DEPTH), .CS_N_HOLD_COUNT(HOLD), .MIN_GAP(GAP)
   ) dut (
      .clk(clk), .rst(rst), .wdata(wdata), .wsel(wsel), .we(we),
      .full(full), .overflow(overflow), .mode(mode), .busy(busy),
      .miso(miso), .rdata(rdata), .rsel(rsel), .rvalid(rvalid),
      .sclk(sclk), .cs_n(cs_n), .mosi(mosi)
   );

   typedef struct {
      logic [SW-1:0] sel;
      logic [W-1:0]  data;
      logic [W-1:0]  rexp;
      logic          cpol;
      logic          cpha;
   } frame_t;

   frame_t exp_q[$];
   int     n_cmp  = 0;
   int     n_fail = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endfunction

   // ---------------- monitor ----------------
   logic           mon_in_frame = 1'b0;
   int             mon_edges    = 0;
   int             frames_done  = 0;
   int             gap_cnt      = 0;
   logic           seen_frame   = 1'b0;
   int             cs_low, samp, viol;
   logic [W-1:0]   word;
   logic           sclk_prev, mosi_prev;
   frame_t         cur;
   logic [NCS-1:0] cs_exp;

   always @(negedge clk) begin : monitor
      logic edge_now, leading, sample;
      if (rst) begin
         mon_in_frame = 1'b0;
         gap_cnt      = GAP;
      end else if (!mon_in_frame) begin
         if (rvalid) chk("rvalid_outside_frame", 32'(rvalid), 32'd0);
         if (cs_n != '1) begin
            chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            mon_in_frame = 1'b1;
            cs_exp = ~(NCS'(1) << cur.sel);
            chk("cs_n_select", 32'(cs_n), 32'(cs_exp));
            chk("sclk_idle_level", 32'(sclk), 32'(cur.cpol));
            if (seen_frame) chk("gap_ge_min", 32'(gap_cnt >= GAP), 32'd1);
            cs_low    = 1;
            mon_edges = 0;
            samp      = 0;
            viol      = 0;
            word      = '0;
            sclk_prev = sclk;
            mosi_prev = mosi;
         end else begin
            gap_cnt++;
         end
      end else if (rvalid) begin
         chk("rdata", 32'(rdata), 32'(cur.rexp));
         chk("rsel", 32'(rsel), 32'(cur.sel));
         chk("mosi_word", 32'(word), 32'(cur.data));
         chk("cs_n_low_cycles", 32'(cs_low), 32'(CS_LOW));
         chk("sclk_edges", 32'(mon_edges), 32'(2 * W));
         chk("sample_edges", 32'(samp), 32'(W));
         chk("mosi_change_off_shift_edge", 32'(viol), 32'd0);
         chk("cs_n_released", 32'(cs_n), 32'(2'b11));
         $display("frame sel=%0d cpol=%0d cpha=%0d mosi=%h rdata=%h cs_low=%0d edges=%0d",
                  cur.sel, cur.cpol, cur.cpha, word, rdata, cs_low, mon_edges);
         mon_in_frame = 1'b0;
         gap_cnt      = 1;
         seen_frame   = 1'b1;
         frames_done++;
      end else begin
         if (cs_n != '1) cs_low++;
         edge_now = (sclk != sclk_prev);
         leading  = edge_now && (sclk_prev == cur.cpol);
         sample   = edge_now && (cur.cpha ? !leading : leading);
         if (edge_now) mon_edges++;
         if (sample) begin
            word = {word[W-2:0], mosi};
            samp++;
         end
         if ((mosi != mosi_prev) && !(edge_now && !sample)) viol++;
         sclk_prev = sclk;
         mosi_prev = mosi;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input logic [SW-1:0] s, input logic [W-1:0] d, input logic [W-1:0] rexp,
                       input logic cpol, input logic cpha, input logic exp_ovf);
      frame_t f;
      @(negedge clk);
      we = 1'b1; wsel = s; wdata = d;
      #1;
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      if (!exp_ovf) begin
         f.sel = s; f.data = d; f.rexp = rexp; f.cpol = cpol; f.cpha = cpha;
         exp_q.push_back(f);
      end
   endtask

   task automatic end_push();
      @(negedge clk);
      we = 1'b0;
      #1;
      chk("overflow_idle", 32'(overflow), 32'd0);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !mon_in_frame && !busy) break;
      end
      chk("idle_within_budget", 32'(k < budget), 32'd1);
   endtask

   task automatic wait_edges(input int n);
      int k;
      for (k = 0; k < 500; k++) begin
         @(negedge clk);
         if (mon_in_frame && mon_edges >= n) break;
      end
      chk("edge_reached", 32'(k < 500), 32'd1);
   endtask

   task automatic wait_rise(output logic ok);
      logic prev;
      prev = sclk;
      ok   = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (sclk && !prev) begin
            ok = 1'b1;
            break;
         end
         prev = sclk;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin : stim
      logic ok;
      repeat (3) @(negedge clk);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_cs_n", 32'(cs_n), 32'(2'b11));
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_rsel", 32'(rsel), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      rst = 1'b0;

      // Mode 0 write to cs 1 (loopback read-back)
      mode = 2'b00;
      repeat (2) @(negedge clk);
      push(1'b1, 16'hA55A, 16'hA55A, 1'b0, 1'b0, 1'b0);
      end_push();
      wait_idle(400);

      // Mode 3 loopback on cs 0
      mode = 2'b11;
      repeat (3) @(negedge clk);
      push(1'b0, 16'h1234, 16'h1234, 1'b1, 1'b1, 1'b0);
      end_push();
      wait_idle(400);

      // Mode 1 with a target shifting out F00F on leading (rising) edges
      mode = 2'b01;
      repeat (3) @(negedge clk);
      tgt_word = 16'hF00F;
      miso_tgt = 1'b0;
      use_tgt  = 1'b1;
      push(1'b0, 16'h8001, 16'hF00F, 1'b0, 1'b1, 1'b0);
      end_push();
      for (int b = W - 1; b >= 0; b--) begin
         wait_rise(ok);
         chk("sclk_rise_seen", 32'(ok), 32'd1);
         if (!ok) break;
         miso_tgt = tgt_word[b];
      end
      wait_idle(400);
      use_tgt = 1'b0;

      // FIFO burst: 5 accepted, 6th dropped with overflow
      mode = 2'b00;
      repeat (3) @(negedge clk);
      push(1'b0, 16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0);
      push(1'b1, 16'h2222, 16'h2222, 1'b0, 1'b0, 1'b0);
      push(1'b0, 16'h3333, 16'h3333, 1'b0, 1'b0, 1'b0);
      push(1'b1, 16'h4444, 16'h4444, 1'b0, 1'b0, 1'b0);
      push(1'b0, 16'h5555, 16'h5555, 1'b0, 1'b0, 1'b0);
      push(1'b1, 16'h6666, 16'h6666, 1'b0, 1'b0, 1'b1);
      end_push();
      chk("full_after_burst", 32'(full), 32'd1);
      wait_idle(2000);
      chk("full_drained", 32'(full), 32'd0);

      // Mode switched 0 -> 2 in the middle of a frame
      push(1'b0, 16'h0F0F, 16'h0F0F, 1'b0, 1'b0, 1'b0);
      push(1'b1, 16'hF0F0, 16'hF0F0, 1'b1, 1'b0, 1'b0);
      end_push();
      wait_edges(4);
      mode = 2'b10;
      wait_idle(800);

      // Reset in the middle of a frame with entries still queued
      mode = 2'b00;
      repeat (3) @(negedge clk);
      push(1'b0, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0, 1'b0);
      push(1'b1, 16'h5555, 16'h5555, 1'b0, 1'b0, 1'b0);
      push(1'b0, 16'h3C3C, 16'h3C3C, 1'b0, 1'b0, 1'b0);
      end_push();
      wait_edges(14);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_cs_n", 32'(cs_n), 32'(2'b11));
      chk("midrst_sclk", 32'(sclk), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_full", 32'(full), 32'd0);
      repeat (3) @(negedge clk);
      exp_q.delete();
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_cs_n", 32'(cs_n), 32'(2'b11));
      push(1'b1, 16'hC3A5, 16'hC3A5, 1'b0, 1'b0, 1'b0);
      end_push();
      wait_idle(400);

      chk("frames_completed", 32'(frames_done), 32'd11);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog expired");
   end

endmodule
